// File: rtl/bitonic_pkg.sv
// Shared helpers for the bitonic merger: key ordering, key slice offsets,
// and the compare distance used by each merge stage.
package bitonic_pkg;

  // Widest key the ordering helper handles; keys are zero-extended to this.
  localparam int KEY_MAX_W = 64;

  // Compare distance of stage s in a depth-level merger (halves every stage).
  function automatic int stage_dist(input int s, input int depth);
    return 1 << (depth - 1 - s);
  endfunction

  // Bit offset of key i inside a packed vector of width-bit keys.
  function automatic int key_lo(input int i, input int width);
    return i * width;
  endfunction

  // a < b on width-bit keys. In signed mode the sign bit is inverted so that
  // two's-complement order maps onto plain unsigned order.
  function automatic logic key_lt(input logic [KEY_MAX_W-1:0] a,
                                  input logic [KEY_MAX_W-1:0] b,
                                  input logic                 signed_mode,
                                  input int                   width);
    logic [KEY_MAX_W-1:0] flip;
    logic [KEY_MAX_W-1:0] a_b;
    logic [KEY_MAX_W-1:0] b_b;
    flip = signed_mode ? (KEY_MAX_W'(1) << (width - 1)) : '0;
    a_b  = a ^ flip;
    b_b  = b ^ flip;
    return a_b < b_b;
  endfunction

endpackage

// File: rtl/bitonic_cas.sv
// Combinational compare-exchange of one key pair. The lower-index output
// takes the min (desc=0) or the max (desc=1); equal keys pass straight through.
module bitonic_cas
  import bitonic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit SIGNED     = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  desc,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);

  logic [KEY_MAX_W-1:0] a_ext;
  logic [KEY_MAX_W-1:0] b_ext;
  logic                 swap;

  // Swap only on strict inequality so ties never move.
  always_comb begin
    a_ext = KEY_MAX_W'(a);
    b_ext = KEY_MAX_W'(b);
    swap  = desc ? key_lt(a_ext, b_ext, SIGNED, DATA_WIDTH)
                 : key_lt(b_ext, a_ext, SIGNED, DATA_WIDTH);
    lo    = swap ? b : a;
    hi    = swap ? a : b;
  end

endmodule

// File: rtl/bitonic_merge_pipe.sv
// Streaming bitonic merger: one registered compare-exchange level per stage,
// per-beat sort direction, valid/ready backpressure, flush and occupancy count.
module bitonic_merge_pipe
  import bitonic_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_DEPTH = 3,
  parameter bit SIGNED      = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [(2**BLOCK_DEPTH)*DATA_WIDTH-1:0] in_data,
  input  logic                                  in_desc,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [(2**BLOCK_DEPTH)*DATA_WIDTH-1:0] out_data,
  output logic                                  out_desc,
  output logic [$clog2(BLOCK_DEPTH+1)-1:0]      in_flight
);

  localparam int KEYS  = 2**BLOCK_DEPTH;
  localparam int VEC_W = KEYS * DATA_WIDTH;
  localparam int CNT_W = $clog2(BLOCK_DEPTH + 1);

  logic [BLOCK_DEPTH-1:0] vld_p;
  logic [BLOCK_DEPTH-1:0] vld_in;
  logic [BLOCK_DEPTH-1:0] vld_nxt;
  logic [BLOCK_DEPTH-1:0] rdy;
  logic                   desc_in [BLOCK_DEPTH];
  logic                   desc_p  [BLOCK_DEPTH];
  logic [VEC_W-1:0]       st_in   [BLOCK_DEPTH];
  logic [VEC_W-1:0]       data_p  [BLOCK_DEPTH];

  function automatic logic [CNT_W-1:0] popcnt(input logic [BLOCK_DEPTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < BLOCK_DEPTH; k++) c = c + CNT_W'(v[k]);
    return c;
  endfunction

  // Ready ripples back from the sink: a stage can take a beat if empty or draining.
  always_comb begin : ready_chain
    logic r;
    r = out_ready;
    for (int k = BLOCK_DEPTH - 1; k >= 0; k--) begin
      r      = !vld_p[k] | r;
      rdy[k] = r;
    end
  end

  // Each stage is fed by the input port (stage 0) or the previous stage register.
  always_comb begin
    vld_in[0]  = in_valid;
    desc_in[0] = in_desc;
    st_in[0]   = in_data;
    for (int s = 1; s < BLOCK_DEPTH; s++) begin
      vld_in[s]  = vld_p[s-1];
      desc_in[s] = desc_p[s-1];
      st_in[s]   = data_p[s-1];
    end
  end

  // Next valid bits: flush empties everything, otherwise advance where ready.
  always_comb begin
    for (int k = 0; k < BLOCK_DEPTH; k++)
      vld_nxt[k] = flush ? 1'b0 : (rdy[k] ? vld_in[k] : vld_p[k]);
  end

  // Valid bits and occupancy; occupancy is registered from the same next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p     <= '0;
      in_flight <= '0;
    end else begin
      vld_p     <= vld_nxt;
      in_flight <= popcnt(vld_nxt);
    end
  end

  for (genvar s = 0; s < BLOCK_DEPTH; s++) begin : g_stage
    localparam int D = stage_dist(s, BLOCK_DEPTH);
    logic [VEC_W-1:0] cas_vec;

    for (genvar i = 0; i < KEYS; i++) begin : g_pair
      if ((i & D) == 0) begin : g_cas
        bitonic_cas #(
          .DATA_WIDTH(DATA_WIDTH),
          .SIGNED    (SIGNED)
        ) u_cas (
          .a   (st_in[s][key_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
          .b   (st_in[s][key_lo(i + D, DATA_WIDTH) +: DATA_WIDTH]),
          .desc(desc_in[s]),
          .lo  (cas_vec[key_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
          .hi  (cas_vec[key_lo(i + D, DATA_WIDTH) +: DATA_WIDTH])
        );
      end
    end

    // ---- stage s register boundary ----
    // Data and direction load only when this stage accepts a beat.
    always_ff @(posedge clk) begin
      if (rdy[s] && vld_in[s]) begin
        data_p[s] <= cas_vec;
        desc_p[s] <= desc_in[s];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_p[BLOCK_DEPTH-1];
  assign out_data  = out_valid ? data_p[BLOCK_DEPTH-1] : '0;
  assign out_desc  = out_valid & desc_p[BLOCK_DEPTH-1];

endmodule
